// File: rtl/cc_transi_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cc_transi_sequencer: tick-paced fill/hold/drain wipe for the TRANSI mux |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module cc_transi_sequencer #(
  parameter int TRANSI_WIDTH  = 8,
  parameter int SELECT_WIDTH  = 2,
  parameter int HOLD_TICKS    = 4,
  parameter int HOLDCNT_WIDTH = 3
) (
  input  logic                    CC_TRANSI_CLOCK_50,
  input  logic                    CC_TRANSI_RESET_InHigh,
  input  logic                    CC_TRANSI_start_In,
  input  logic                    CC_TRANSI_abort_In,
  input  logic                    CC_TRANSI_tick_In,
  output logic [TRANSI_WIDTH-1:0] CC_TRANSI_TRANSI_OutBUS,
  output logic [SELECT_WIDTH-1:0] CC_TRANSI_select_OutBUS,
  output logic                    CC_TRANSI_busy_Out,
  output logic                    CC_TRANSI_done_Out
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_FILL  = 3'd1;
  localparam logic [2:0] c_HOLD  = 3'd2;
  localparam logic [2:0] c_DRAIN = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  // A HOLD_TICKS of zero still spends one tick in HOLD.
  localparam logic [HOLDCNT_WIDTH-1:0] c_HOLD_LAST =
    (HOLD_TICKS > 1) ? HOLDCNT_WIDTH'(HOLD_TICKS - 1) : '0;
  localparam logic [TRANSI_WIDTH-1:0] c_FIRST_BUS    = TRANSI_WIDTH'(1);
  localparam logic [SELECT_WIDTH-1:0] c_SEL_NORMAL   = SELECT_WIDTH'(1);
  localparam logic [SELECT_WIDTH-1:0] c_SEL_TRANSI   = '0;

  logic [2:0]               r_state;
  logic [2:0]               w_nextState;
  logic [TRANSI_WIDTH-1:0]  r_transiBus;
  logic [TRANSI_WIDTH-1:0]  w_nextBus;
  logic [TRANSI_WIDTH-1:0]  w_fillBus;
  logic [TRANSI_WIDTH-1:0]  w_drainBus;
  logic [HOLDCNT_WIDTH-1:0] r_holdCnt;
  logic [HOLDCNT_WIDTH-1:0] w_nextHoldCnt;
  logic [SELECT_WIDTH-1:0]  r_select;
  logic [SELECT_WIDTH-1:0]  w_nextSelect;
  logic                     r_busy;
  logic                     w_nextBusy;
  logic                     r_done;
  logic                     w_nextDone;

  assign w_fillBus  = {r_transiBus[TRANSI_WIDTH-2:0], 1'b1};
  assign w_drainBus = {r_transiBus[TRANSI_WIDTH-2:0], 1'b0};

  always_ff @(posedge CC_TRANSI_CLOCK_50 or posedge CC_TRANSI_RESET_InHigh) begin
    if (CC_TRANSI_RESET_InHigh) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextBus     = r_transiBus;
    w_nextHoldCnt = r_holdCnt;
    if (CC_TRANSI_abort_In) begin
      w_nextState   = c_IDLE;
      w_nextBus     = '0;
      w_nextHoldCnt = '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          w_nextBus     = '0;
          w_nextHoldCnt = '0;
          if (CC_TRANSI_start_In) begin
            w_nextState = c_FILL;
            w_nextBus   = c_FIRST_BUS;
          end
        end
        c_FILL: begin
          if (CC_TRANSI_tick_In) begin
            w_nextBus = w_fillBus;
            if (&w_fillBus) begin
              w_nextState   = c_HOLD;
              w_nextHoldCnt = '0;
            end
          end
        end
        c_HOLD: begin
          if (CC_TRANSI_tick_In) begin
            if (r_holdCnt == c_HOLD_LAST) begin
              w_nextState   = c_DRAIN;
              w_nextHoldCnt = '0;
            end else begin
              w_nextHoldCnt = r_holdCnt + HOLDCNT_WIDTH'(1);
            end
          end
        end
        c_DRAIN: begin
          if (CC_TRANSI_tick_In) begin
            w_nextBus = w_drainBus;
            if (w_drainBus == '0) begin
              w_nextState = c_DONE;
            end
          end
        end
        c_DONE: begin
          w_nextState = c_IDLE;
          w_nextBus   = '0;
        end
        default: begin
          w_nextState   = c_IDLE;
          w_nextBus     = '0;
          w_nextHoldCnt = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_nextSelect = c_SEL_NORMAL;
    w_nextBusy   = 1'b0;
    w_nextDone   = 1'b0;
    case (w_nextState)
      c_FILL, c_HOLD, c_DRAIN: begin
        w_nextSelect = c_SEL_TRANSI;
        w_nextBusy   = 1'b1;
      end
      c_DONE: begin
        w_nextDone = 1'b1;
      end
      default: begin
        w_nextSelect = c_SEL_NORMAL;
      end
    endcase
  end

  always_ff @(posedge CC_TRANSI_CLOCK_50 or posedge CC_TRANSI_RESET_InHigh) begin
    if (CC_TRANSI_RESET_InHigh) begin
      r_transiBus <= '0;
      r_holdCnt   <= '0;
      r_select    <= c_SEL_NORMAL;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_transiBus <= w_nextBus;
      r_holdCnt   <= w_nextHoldCnt;
      r_select    <= w_nextSelect;
      r_busy      <= w_nextBusy;
      r_done      <= w_nextDone;
    end
  end

  assign CC_TRANSI_TRANSI_OutBUS = r_transiBus;
  assign CC_TRANSI_select_OutBUS = r_select;
  assign CC_TRANSI_busy_Out      = r_busy;
  assign CC_TRANSI_done_Out      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cc_transi_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_cc_transi_sequencer: scoreboard bench for the wipe sequencer        |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_cc_transi_sequencer;

  localparam int M_IDLE  = 0;
  localparam int M_FILL  = 1;
  localparam int M_HOLD  = 2;
  localparam int M_DRAIN = 3;
  localparam int M_DONE  = 4;
  localparam logic [11:0] c_RESET_VEC = {8'h00, 2'd1, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, tick;
  logic [7:0] bus;
  logic [1:0] sel;
  logic       busy, done;

  logic       start0, abort0, tick0;
  logic [7:0] bus0;
  logic [1:0] sel0;
  logic       busy0, done0;

  int compared   = 0;
  int mismatched = 0;

  logic [11:0] sb[$];
  logic [7:0]  sb0[$];

  int         mState;
  logic [7:0] mBus;
  int         mHoldSeen;

  always #5 clk = ~clk;

  cc_transi_sequencer dut (
    .CC_TRANSI_CLOCK_50      (clk),
    .CC_TRANSI_RESET_InHigh  (rst),
    .CC_TRANSI_start_In      (start),
    .CC_TRANSI_abort_In      (abort),
    .CC_TRANSI_tick_In       (tick),
    .CC_TRANSI_TRANSI_OutBUS (bus),
    .CC_TRANSI_select_OutBUS (sel),
    .CC_TRANSI_busy_Out      (busy),
    .CC_TRANSI_done_Out      (done)
  );

  cc_transi_sequencer #(.HOLD_TICKS(0)) dut0 (
    .CC_TRANSI_CLOCK_50      (clk),
    .CC_TRANSI_RESET_InHigh  (rst),
    .CC_TRANSI_start_In      (start0),
    .CC_TRANSI_abort_In      (abort0),
    .CC_TRANSI_tick_In       (tick0),
    .CC_TRANSI_TRANSI_OutBUS (bus0),
    .CC_TRANSI_select_OutBUS (sel0),
    .CC_TRANSI_busy_Out      (busy0),
    .CC_TRANSI_done_Out      (done0)
  );

  // Reference model for the default build: predicts outputs after the next edge.
  task automatic cycle(input logic s, input logic a, input logic t);
    logic active;
    start = s;
    abort = a;
    tick  = t;
    if (rst || a) begin
      mState = M_IDLE; mBus = 8'h00; mHoldSeen = 0;
    end else begin
      case (mState)
        M_IDLE:  if (s) begin mState = M_FILL; mBus = 8'h01; end
        M_FILL:  if (t) begin
                   mBus = {mBus[6:0], 1'b1};
                   if (mBus == 8'hFF) begin mState = M_HOLD; mHoldSeen = 0; end
                 end
        M_HOLD:  if (t) begin
                   mHoldSeen = mHoldSeen + 1;
                   if (mHoldSeen == 4) mState = M_DRAIN;
                 end
        M_DRAIN: if (t) begin
                   mBus = {mBus[6:0], 1'b0};
                   if (mBus == 8'h00) mState = M_DONE;
                 end
        default: begin mState = M_IDLE; mBus = 8'h00; end
      endcase
    end
    active = (mState == M_FILL) || (mState == M_HOLD) || (mState == M_DRAIN);
    sb.push_back({mBus, active ? 2'd0 : 2'd1, active, mState == M_DONE});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    rst = 1'b1;
    start = 0; abort = 0; tick = 0;
    start0 = 0; abort0 = 0; tick0 = 0;
    mState = M_IDLE; mBus = 8'h00; mHoldSeen = 0;
    #12;
    compared++;
    if ({bus, sel, busy, done} !== c_RESET_VEC) begin
      mismatched++;
      $display("FAIL reset_values: got %h required %h", {bus, sel, busy, done}, c_RESET_VEC);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, (i % 3) == 0);
      exp = sb.pop_front();
      compared++;
      if ({bus, sel, busy, done} !== exp) begin
        mismatched++;
        $display("FAIL idle_quiet[%0d]: got %h required %h", i, {bus, sel, busy, done}, exp);
      end
    end
  endtask

  task automatic test_basic_wipe();
    logic [11:0] exp;
    int dones = 0;
    for (int i = 0; i < 1 + 19 * 4; i++) begin
      cycle(i == 0, 1'b0, (i > 0) && ((i - 1) % 4 == 0));
      exp = sb.pop_front();
      compared++;
      if ({bus, sel, busy, done} !== exp) begin
        mismatched++;
        $display("FAIL basic_wipe[%0d]: got %h required %h", i, {bus, sel, busy, done}, exp);
      end
      if (done) dones++;
    end
    compared++;
    if (dones !== 1) begin
      mismatched++;
      $display("FAIL basic_done_pulses: got %0d required 1", dones);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp;
    int dones = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      exp = sb.pop_front();
      compared++;
      if ({bus, sel, busy, done} !== exp) begin
        mismatched++;
        $display("FAIL back_to_back[%0d]: got %h required %h", i, {bus, sel, busy, done}, exp);
      end
      if (done) dones++;
    end
    compared++;
    if (dones !== 2) begin
      mismatched++;
      $display("FAIL b2b_done_pulses: got %0d required 2", dones);
    end
    cycle(1'b0, 1'b1, 1'b0);
    exp = sb.pop_front();
    compared++;
    if ({bus, sel, busy, done} !== exp) begin
      mismatched++;
      $display("FAIL b2b_abort_out: got %h required %h", {bus, sel, busy, done}, exp);
    end
  endtask

  task automatic test_abort();
    logic [11:0] exp;
    logic [2:0]  stim[$];
    stim.push_back(3'b100);
    for (int i = 0; i < 9; i++) stim.push_back(3'b001);
    stim.push_back(3'b111);
    stim.push_back(3'b000);
    stim.push_back(3'b100);
    stim.push_back(3'b001);
    foreach (stim[i]) begin
      cycle(stim[i][2], stim[i][1], stim[i][0]);
      exp = sb.pop_front();
      compared++;
      if ({bus, sel, busy, done} !== exp) begin
        mismatched++;
        $display("FAIL abort[%0d]: got %h required %h", i, {bus, sel, busy, done}, exp);
      end
    end
    cycle(1'b0, 1'b1, 1'b0);
    exp = sb.pop_front();
    compared++;
    if ({bus, sel, busy, done} !== exp) begin
      mismatched++;
      $display("FAIL abort_cleanup: got %h required %h", {bus, sel, busy, done}, exp);
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] exp;
    cycle(1'b1, 1'b0, 1'b0);
    exp = sb.pop_front();
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      exp = sb.pop_front();
    end
    compared++;
    if (bus !== 8'hF0) begin
      mismatched++;
      $display("FAIL drain_f0: got %h required f0", bus);
    end
    tick = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if ({bus, sel, busy, done} !== c_RESET_VEC) begin
      mismatched++;
      $display("FAIL async_reset: got %h required %h", {bus, sel, busy, done}, c_RESET_VEC);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mState = M_IDLE; mBus = 8'h00; mHoldSeen = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      exp = sb.pop_front();
      compared++;
      if ({bus, sel, busy, done} !== exp) begin
        mismatched++;
        $display("FAIL post_reset_idle[%0d]: got %h required %h", i, {bus, sel, busy, done}, exp);
      end
    end
  endtask

  task automatic test_hold_zero();
    logic [7:0] expBus;
    logic [7:0] got;
    int ticksToDone = 0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    compared++;
    if (bus0 !== 8'h01 || sel0 !== 2'd0 || busy0 !== 1'b1) begin
      mismatched++;
      $display("FAIL hold0_start: got bus %h sel %0d busy %b required 01/0/1", bus0, sel0, busy0);
    end
    for (int k = 1; k <= 40 && ticksToDone == 0; k++) begin
      if (k <= 7)      expBus = 8'((9'd1 << (k + 1)) - 9'd1);
      else if (k == 8) expBus = 8'hFF;
      else             expBus = 8'hFF << (k - 8);
      sb0.push_back(expBus);
      tick0 = 1'b1;
      @(posedge clk); #1;
      tick0 = 1'b0;
      got = sb0.pop_front();
      if (k <= 17) begin
        compared++;
        if (bus0 !== got) begin
          mismatched++;
          $display("FAIL hold0_tick%0d: got %h required %h", k, bus0, got);
        end
      end
      if (done0) ticksToDone = k;
    end
    compared++;
    if (ticksToDone !== 16) begin
      mismatched++;
      $display("FAIL hold0_total_ticks: got %0d required 16", ticksToDone);
    end
    @(posedge clk); #1;
    compared++;
    if (done0 !== 1'b0 || sel0 !== 2'd1) begin
      mismatched++;
      $display("FAIL hold0_after_done: got done %b sel %0d required 0/1", done0, sel0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_wipe();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_hold_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
